dbg_trace_buf: RTL and testbench
================================

// Module: dbg_trace_buf
// PURPOSE
//  Multi-lane commit trace buffer for the debugger; generalises the per-signal DPI updater.
//  Captures up to NCOMMIT retired instructions per cycle into a DEPTH-entry FIFO.
//  Drains entries one per cycle over a valid/ready port to the DPI trace consumer.
//  Raises a sticky halt request on ebreak/invalid only after every older trace entry has drained.
// PARAMETERS
//  NCOMMIT  2   commit lanes per cycle (1..4)
//  DEPTH    16  FIFO entries; power of 2, >= 2*NCOMMIT
//  XLEN     32  pc/inst width
// PORTS
//  clk            in   1              clock, all state updates on posedge
//  reset          in   1              asynchronous, active-low; state cleared while 0
//  commit_valid   in   NCOMMIT        lane i retires this cycle
//  commit_pc      in   NCOMMIT*XLEN   lane i pc at bits [i*XLEN +: XLEN]
//  commit_inst    in   NCOMMIT*XLEN   lane i instruction word
//  commit_ebreak  in   NCOMMIT        lane i is ebreak
//  commit_invalid in   NCOMMIT        lane i is an illegal instruction
//  commit_ready   out  1              buffer accepts a full commit group this cycle
//  trace_valid    out  1              head entry available
//  trace_ready    in   1              consumer takes head entry
//  trace_pc       out  XLEN           head pc
//  trace_inst     out  XLEN           head instruction
//  trace_cause    out  2              head cause: 00 normal, 01 ebreak, 10 invalid
//  halt_req       out  1              sticky halt request
//  halt_cause     out  2              01 ebreak, 10 invalid; 00 when halt_req=0
//  halt_clr       in   1              clears halt state (pulse)
//  occupancy      out  $clog2(DEPTH)+1  current entry count
//  drop_cnt       out  16             saturating count of commits lost
// BEHAVIOUR
//  Reset: FIFO empty, occupancy=0, trace_valid=0, trace_pc/inst/cause=0, halt_req=0,
//   halt_cause=0, drop_cnt=0, internal state RUN, commit_ready=1.
//  commit_ready = (state==RUN) && (DEPTH-occupancy >= NCOMMIT); combinational from registered state.
//  Accepted lanes: commit_valid[i] && no lower lane j<=i... with ebreak/invalid at j<i; lanes above
//   the first ebreak/invalid lane are discarded silently (not counted as drops).
//  Accepted lanes are written in lane order at wr_ptr, wr_ptr+1,...; count = popcount of accepted lanes.
//  If commit_ready=0 and state==RUN, every valid lane is dropped; drop_cnt += that count, saturates 0xFFFF.
//  In states HALT_PEND/HALTED all commits are ignored and not counted.
//  Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; occupancy tracked separately.
//  Output: trace_* driven from FIFO head (registered storage, combinational read); trace_valid=(occupancy!=0).
//  Pop when trace_valid && trace_ready; push and pop in same cycle both apply,
//   occupancy += pushed - popped.
//  Latency: entry written at edge N is visible on trace_* after edge N (0-cycle bypass not provided).
//  FSM: RUN -> HALT_PEND when an ebreak/invalid lane is accepted (entry also enqueued; cause latched,
//   ebreak wins if both flags set on one lane).
//  HALT_PEND -> HALTED when occupancy becomes 0 (after the halting entry is popped); halt_req=1 in HALTED.
//  HALTED -> RUN on halt_clr; halt_cause cleared to 0. halt_clr in RUN/HALT_PEND: no effect.
//  Reset deasserted mid-operation: no partial state survives; buffered entries are lost.
// TESTING
//  1 lane0 pc=0x80000000 valid, trace_ready=1 -> next cycle trace_valid=1, pc=0x80000000, cause=00, pops.
//  2 NCOMMIT=2, both lanes valid pc 0x100/0x104, trace_ready=0 -> occupancy 2, drained in order 0x100 then 0x104.
//  3 fill to DEPTH-1 with trace_ready=0, then 2-lane commit -> commit_ready=0, drop_cnt=2, occupancy unchanged.
//  4 lane0 ebreak pc=0x200, lane1 valid pc=0x204 -> only 0x200 enqueued (cause 01); halt_req=1 one
//    cycle after it is popped; later commits ignored; halt_clr -> halt_req=0, commits accepted.
//  5 occupancy=DEPTH-2, simultaneous 2-lane push and pop -> occupancy DEPTH-1, wr_ptr wraps to 0 correctly.
//  6 reset pulled low with 5 entries buffered and halt pending -> all outputs to reset values immediately.

Source files
------------

// File: rtl/dbg_trace_buf.sv
// Multi-lane commit trace buffer: captures retired instructions into a FIFO,
// drains them to the trace consumer, and raises a halt once older entries drain.
module dbg_trace_buf #(
  parameter int unsigned NCOMMIT = 2,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned XLEN    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NCOMMIT-1:0]        commit_valid,
  input  logic [NCOMMIT*XLEN-1:0]   commit_pc,
  input  logic [NCOMMIT*XLEN-1:0]   commit_inst,
  input  logic [NCOMMIT-1:0]        commit_ebreak,
  input  logic [NCOMMIT-1:0]        commit_invalid,
  output logic                      commit_ready,
  output logic                      trace_valid,
  input  logic                      trace_ready,
  output logic [XLEN-1:0]           trace_pc,
  output logic [XLEN-1:0]           trace_inst,
  output logic [1:0]                trace_cause,
  output logic                      halt_req,
  output logic [1:0]                halt_cause,
  input  logic                      halt_clr,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [15:0]               drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;

  state_t          state;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [1:0]      pend_cause;

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [XLEN-1:0] mem_inst  [DEPTH];
  logic [1:0]      mem_cause [DEPTH];

  logic [NCOMMIT-1:0] accept;
  logic [AW-1:0]      lane_off [NCOMMIT];
  logic [1:0]         lane_cause [NCOMMIT];
  logic [OW-1:0]      push_cnt;
  logic [OW-1:0]      valid_cnt;
  logic               halt_hit;
  logic [1:0]         hit_cause;
  logic               stop;
  logic               pop;
  logic [OW-1:0]      occ_next;
  logic [16:0]        drop_sum;

  assign commit_ready = (state == RUN) &&
                        ((OW'(DEPTH) - occupancy) >= OW'(NCOMMIT));

  // Lanes above the first valid ebreak/invalid lane are cut off; the halting
  // lane itself is still enqueued. Each accepted lane gets a packed slot offset.
  always_comb begin
    accept    = '0;
    push_cnt  = '0;
    valid_cnt = '0;
    halt_hit  = 1'b0;
    hit_cause = 2'b00;
    stop      = 1'b0;
    for (int unsigned i = 0; i < NCOMMIT; i++) begin
      lane_off[i]   = push_cnt[AW-1:0];
      lane_cause[i] = commit_ebreak[i]  ? 2'b01 :
                      commit_invalid[i] ? 2'b10 : 2'b00;
      if (commit_valid[i])
        valid_cnt = valid_cnt + OW'(1);
      if (commit_valid[i] && !stop && commit_ready) begin
        accept[i] = 1'b1;
        push_cnt  = push_cnt + OW'(1);
        if (lane_cause[i] != 2'b00) begin
          halt_hit  = 1'b1;
          hit_cause = lane_cause[i];
        end
      end
      if (commit_valid[i] && (commit_ebreak[i] || commit_invalid[i]))
        stop = 1'b1;
    end
  end

  assign trace_valid = (occupancy != '0);
  assign pop         = trace_valid && trace_ready;
  assign occ_next    = occupancy + push_cnt - OW'(pop);
  assign drop_sum    = {1'b0, drop_cnt} + 17'(valid_cnt);

  assign trace_pc    = trace_valid ? mem_pc[rd_ptr]    : '0;
  assign trace_inst  = trace_valid ? mem_inst[rd_ptr]  : '0;
  assign trace_cause = trace_valid ? mem_cause[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NCOMMIT; i++) begin
      if (accept[i]) begin
        mem_pc[wr_ptr + lane_off[i]]    <= commit_pc[i*XLEN +: XLEN];
        mem_inst[wr_ptr + lane_off[i]]  <= commit_inst[i*XLEN +: XLEN];
        mem_cause[wr_ptr + lane_off[i]] <= lane_cause[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      drop_cnt   <= '0;
      halt_req   <= 1'b0;
      halt_cause <= 2'b00;
      pend_cause <= 2'b00;
    end else begin
      wr_ptr    <= wr_ptr + push_cnt[AW-1:0];
      rd_ptr    <= rd_ptr + AW'(pop);
      occupancy <= occ_next;
      if (state == RUN && !commit_ready && valid_cnt != '0)
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      case (state)
        RUN: begin
          if (halt_hit) begin
            state      <= HALT_PEND;
            pend_cause <= hit_cause;
          end
        end
        HALT_PEND: begin
          if (occ_next == '0) begin
            state      <= HALTED;
            halt_req   <= 1'b1;
            halt_cause <= pend_cause;
          end
        end
        HALTED: begin
          if (halt_clr) begin
            state      <= RUN;
            halt_req   <= 1'b0;
            halt_cause <= 2'b00;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_trace_buf.sv
// Directed bench for dbg_trace_buf (NCOMMIT=2, DEPTH=16, XLEN=32).
module tb_dbg_trace_buf;

  localparam int unsigned NCOMMIT = 2;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned XLEN    = 32;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NCOMMIT-1:0]      commit_valid;
  logic [NCOMMIT*XLEN-1:0] commit_pc;
  logic [NCOMMIT*XLEN-1:0] commit_inst;
  logic [NCOMMIT-1:0]      commit_ebreak;
  logic [NCOMMIT-1:0]      commit_invalid;
  logic                    commit_ready;
  logic                    trace_valid;
  logic                    trace_ready;
  logic [XLEN-1:0]         trace_pc;
  logic [XLEN-1:0]         trace_inst;
  logic [1:0]              trace_cause;
  logic                    halt_req;
  logic [1:0]              halt_cause;
  logic                    halt_clr;
  logic [$clog2(DEPTH):0]  occupancy;
  logic [15:0]             drop_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  dbg_trace_buf #(.NCOMMIT(NCOMMIT), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .commit_valid   (commit_valid),
    .commit_pc      (commit_pc),
    .commit_inst    (commit_inst),
    .commit_ebreak  (commit_ebreak),
    .commit_invalid (commit_invalid),
    .commit_ready   (commit_ready),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_pc       (trace_pc),
    .trace_inst     (trace_inst),
    .trace_cause    (trace_cause),
    .halt_req       (halt_req),
    .halt_cause     (halt_cause),
    .halt_clr       (halt_clr),
    .occupancy      (occupancy),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h0000_0013;
  endfunction

  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [1:0] eb, input logic [1:0] inv);
    commit_valid   = v;
    commit_pc      = {pc1, pc0};
    commit_inst    = {inst_of(pc1), inst_of(pc0)};
    commit_ebreak  = eb;
    commit_invalid = inv;
  endtask

  // One clock edge; inputs are re-idled at the following falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    commit_valid   = '0;
    commit_ebreak  = '0;
    commit_invalid = '0;
    halt_clr       = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    trace_ready = 1'b0;
    halt_clr    = 1'b0;
    drive(2'b00, '0, '0, 2'b00, 2'b00);
    @(negedge clk);
    @(negedge clk);

    check("rst_occ",   32'(occupancy),    32'd0);
    check("rst_tv",    32'(trace_valid),  32'd0);
    check("rst_pc",    trace_pc,          32'd0);
    check("rst_cause", 32'(trace_cause),  32'd0);
    check("rst_cr",    32'(commit_ready), 32'd1);
    check("rst_halt",  32'(halt_req),     32'd0);
    check("rst_hc",    32'(halt_cause),   32'd0);
    check("rst_drop",  32'(drop_cnt),     32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single lane, consumer ready
    trace_ready = 1'b1;
    drive(2'b01, 32'h8000_0000, 32'h0, 2'b00, 2'b00);
    cycle();
    check("t1_tv",    32'(trace_valid), 32'd1);
    check("t1_pc",    trace_pc,         32'h8000_0000);
    check("t1_inst",  trace_inst,       32'h8000_0013);
    check("t1_cause", 32'(trace_cause), 32'd0);
    cycle();
    check("t1_popped", 32'(occupancy),  32'd0);
    check("t1_tv0",    32'(trace_valid), 32'd0);

    // Two lanes, drained in order
    trace_ready = 1'b0;
    drive(2'b11, 32'h100, 32'h104, 2'b00, 2'b00);
    cycle();
    check("t2_occ", 32'(occupancy), 32'd2);
    check("t2_pc0", trace_pc,       32'h100);
    trace_ready = 1'b1;
    cycle();
    check("t2_pc1",  trace_pc,       32'h104);
    check("t2_occ1", 32'(occupancy), 32'd1);
    cycle();
    check("t2_occ0", 32'(occupancy), 32'd0);

    // Fill to DEPTH-1, then a dropped 2-lane group
    trace_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive(2'b11, 32'h1000 + 32'(8*k), 32'h1004 + 32'(8*k), 2'b00, 2'b00);
      cycle();
    end
    drive(2'b01, 32'h1038, 32'h0, 2'b00, 2'b00);
    cycle();
    check("t3_occ15", 32'(occupancy), 32'd15);
    drive(2'b11, 32'hDEAD_0000, 32'hDEAD_0004, 2'b00, 2'b00);
    check("t3_cr0", 32'(commit_ready), 32'd0);
    cycle();
    check("t3_drop",   32'(drop_cnt),  32'd2);
    check("t3_occ",    32'(occupancy), 32'd15);
    trace_ready = 1'b1;
    for (int j = 0; j < 15; j++) begin
      check("t3_drain", trace_pc, 32'h1000 + 32'(4*j));
      cycle();
    end
    check("t3_empty", 32'(occupancy), 32'd0);

    // Streaming push+pop each cycle, also rotates the pointers
    for (int j = 0; j < 15; j++) begin
      drive(2'b01, 32'h2000 + 32'(4*j), 32'h0, 2'b00, 2'b00);
      cycle();
      check("stream_pc",  trace_pc,       32'h2000 + 32'(4*j));
      check("stream_occ", 32'(occupancy), 32'd1);
    end
    cycle();
    check("stream_empty", 32'(occupancy), 32'd0);

    // DEPTH-2 entries, then 2-lane push with pop across the wrap
    trace_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive(2'b11, 32'h3000 + 32'(8*k), 32'h3004 + 32'(8*k), 2'b00, 2'b00);
      cycle();
    end
    check("t5_occ14", 32'(occupancy),    32'd14);
    check("t5_cr",    32'(commit_ready), 32'd1);
    trace_ready = 1'b1;
    drive(2'b11, 32'h3038, 32'h303C, 2'b00, 2'b00);
    cycle();
    check("t5_occ15", 32'(occupancy), 32'd15);
    for (int j = 0; j < 15; j++) begin
      check("t5_drain", trace_pc, 32'h3004 + 32'(4*j));
      cycle();
    end
    check("t5_empty", 32'(occupancy), 32'd0);

    // ebreak on lane 0 truncates lane 1, halt after drain
    trace_ready = 1'b0;
    drive(2'b11, 32'h200, 32'h204, 2'b01, 2'b00);
    cycle();
    check("t4_occ",   32'(occupancy),    32'd1);
    check("t4_pc",    trace_pc,          32'h200);
    check("t4_cause", 32'(trace_cause),  32'd1);
    check("t4_cr",    32'(commit_ready), 32'd0);
    check("t4_nohlt", 32'(halt_req),     32'd0);
    drive(2'b01, 32'h300, 32'h0, 2'b00, 2'b00);
    halt_clr = 1'b1;
    cycle();
    check("t4_pend_occ",  32'(occupancy), 32'd1);
    check("t4_pend_drop", 32'(drop_cnt),  32'd2);
    check("t4_pend_clr",  32'(halt_req),  32'd0);
    trace_ready = 1'b1;
    cycle();
    check("t4_halt", 32'(halt_req),   32'd1);
    check("t4_hc",   32'(halt_cause), 32'd1);
    check("t4_occ0", 32'(occupancy),  32'd0);
    trace_ready = 1'b0;
    drive(2'b11, 32'h300, 32'h304, 2'b00, 2'b00);
    cycle();
    check("t4_ign_occ",  32'(occupancy), 32'd0);
    check("t4_ign_drop", 32'(drop_cnt),  32'd2);
    halt_clr = 1'b1;
    cycle();
    check("t4_clr",    32'(halt_req),     32'd0);
    check("t4_clr_hc", 32'(halt_cause),   32'd0);
    check("t4_clr_cr", 32'(commit_ready), 32'd1);
    drive(2'b01, 32'h400, 32'h0, 2'b00, 2'b00);
    cycle();
    check("t4_resume", trace_pc, 32'h400);

    // invalid on lane 1 with both flags-free lane 0
    drive(2'b11, 32'h500, 32'h504, 2'b00, 2'b10);
    cycle();
    check("inv_occ", 32'(occupancy), 32'd3);
    trace_ready = 1'b1;
    check("inv_pc0", trace_pc, 32'h400);
    cycle();
    check("inv_pc1", trace_pc, 32'h500);
    cycle();
    check("inv_pc2",    trace_pc,          32'h504);
    check("inv_cause",  32'(trace_cause),  32'd2);
    check("inv_nohalt", 32'(halt_req),     32'd0);
    cycle();
    check("inv_halt", 32'(halt_req),   32'd1);
    check("inv_hc",   32'(halt_cause), 32'd2);
    halt_clr = 1'b1;
    cycle();
    check("inv_clr", 32'(halt_req), 32'd0);

    // Reset with entries buffered and halt pending
    trace_ready = 1'b0;
    drive(2'b11, 32'h600, 32'h604, 2'b00, 2'b00);
    cycle();
    drive(2'b11, 32'h608, 32'h60C, 2'b00, 2'b00);
    cycle();
    drive(2'b01, 32'h610, 32'h0, 2'b01, 2'b00);
    cycle();
    check("t6_occ5", 32'(occupancy),    32'd5);
    check("t6_cr0",  32'(commit_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("t6_occ",  32'(occupancy),    32'd0);
    check("t6_tv",   32'(trace_valid),  32'd0);
    check("t6_pc",   trace_pc,          32'd0);
    check("t6_cr",   32'(commit_ready), 32'd1);
    check("t6_halt", 32'(halt_req),     32'd0);
    check("t6_drop", 32'(drop_cnt),     32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(2'b01, 32'h700, 32'h0, 2'b00, 2'b00);
    cycle();
    check("t6_after_occ", 32'(occupancy), 32'd1);
    check("t6_after_pc",  trace_pc,       32'h700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
